// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the round-robin memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned NREQ_DEF = 2;
    localparam int unsigned AW_DEF   = 4;
    localparam int unsigned DW_DEF   = 8;
    localparam int unsigned CW_DEF   = 16;

    // Access type of the granted requester
    typedef enum logic {
        ARB_RD = 1'b0,
        ARB_WR = 1'b1
    } arb_op_e;

endpackage

// File: rtl/mem_rr_port_arbiter_if.sv
// Request/response bus between requesters and the shared memory arbiter.
interface mem_rr_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ*DW-1:0] req_wmask;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_rr_pick.sv
// Round-robin picker: first valid requester at or after rr_ptr, with wrap.
module mem_rr_pick #(
    parameter int unsigned  NREQ = 2,
    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_vld
);

    int unsigned   pos;
    logic [PW-1:0] idx;

    // Scan NREQ slots starting at rr_ptr; first valid slot wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = 32'(rr_ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            idx = PW'(pos);
            if (!grant_vld && req_valid[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mem_rr_port_arbiter.sv
// Single-port memory shared by NREQ requesters under round-robin arbitration.
// One access per cycle; masked writes; reads return one cycle after accept.
module mem_rr_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned CW   = CW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_rr_port_arbiter_if.slave  bus,
    output logic [CW-1:0]         stall_cnt
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [DW-1:0]   mem [DEPTH];
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   next_ptr;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            grant_vld;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [DW-1:0]   sel_wmask;
    arb_op_e         sel_op;
    logic            rd_acc;
    logic            wr_acc;
    logic            stall;

    mem_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // Grant is suppressed while in reset so nothing is accepted
    assign bus.req_ready = rst_n ? grant : '0;

    // Mux the granted requester's payload using the one-hot grant
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr  = bus.req_addr[i*AW +: AW];
                sel_wdata = bus.req_wdata[i*DW +: DW];
                sel_wmask = bus.req_wmask[i*DW +: DW];
            end
        end
    end

    assign sel_op   = arb_op_e'(|(grant & bus.req_we));
    assign rd_acc   = rst_n && grant_vld && (sel_op == ARB_RD);
    assign wr_acc   = rst_n && grant_vld && (sel_op == ARB_WR);
    assign stall    = |(bus.req_valid & ~grant);
    assign next_ptr = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);

    // Pointer, read response and stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            stall_cnt     <= '0;
        end else begin
            if (grant_vld) begin
                rr_ptr <= next_ptr;
            end
            bus.rsp_valid <= rd_acc ? grant : '0;
            if (rd_acc) begin
                bus.rsp_rdata <= mem[sel_addr];
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
        end
    end

    // Masked write; memory contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[sel_addr] <= (mem[sel_addr] & ~sel_wmask) | (sel_wdata & sel_wmask);
        end
    end

endmodule

// File: tb/tb_mem_rr_port_arbiter.sv
// Directed self-checking bench for mem_rr_port_arbiter and mem_rr_pick.
module tb_mem_rr_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    // picker unit under test (4 requesters)
    logic [3:0] pk_valid;
    logic [1:0] pk_ptr;
    logic [3:0] pk_grant;
    logic [1:0] pk_idx;
    logic       pk_vld;

    always #5 clk = ~clk;

    mem_rr_port_arbiter_if #(.NREQ(2), .AW(4), .DW(8)) bus ();
    mem_rr_port_arbiter_if #(.NREQ(2), .AW(4), .DW(8)) bus2 ();

    mem_rr_port_arbiter #(.NREQ(2), .AW(4), .DW(8), .CW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt)
    );

    mem_rr_port_arbiter #(.NREQ(2), .AW(4), .DW(8), .CW(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus2.slave),
        .stall_cnt (stall_cnt2)
    );

    mem_rr_pick #(.NREQ(4)) u_pick (
        .req_valid (pk_valid),
        .rr_ptr    (pk_ptr),
        .grant     (pk_grant),
        .grant_idx (pk_idx),
        .grant_vld (pk_vld)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
        bus.req_valid[i]        = v;
        bus.req_we[i]           = we;
        bus.req_addr[i*4 +: 4]  = a;
        bus.req_wdata[i*8 +: 8] = d;
        bus.req_wmask[i*8 +: 8] = m;
    endtask

    task automatic idle_all;
        bus.req_valid  = '0;
        bus.req_we     = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wmask  = '0;
        bus2.req_valid = '0;
        bus2.req_we    = '0;
        bus2.req_addr  = '0;
        bus2.req_wdata = '0;
        bus2.req_wmask = '0;
    endtask

    task automatic do_reset;
        idle_all();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        idle_all();
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        tick();
        tick();
        total_cnt++;
        if (bus.req_ready !== 2'b00) $display("FAIL reset_ready: got %b expected 00", bus.req_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 16'd0) $display("FAIL reset_stall: got %0d expected 0", stall_cnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.rsp_rdata !== 8'h00) $display("FAIL reset_rdata: got %h expected 00", bus.rsp_rdata);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (bus.req_ready !== 2'b01) $display("FAIL first_grant: got %b expected 01", bus.req_ready);
        else pass_cnt++;
        idle_all();
    endtask

    task automatic test_masked_write;
        do_reset();
        set_req(0, 1'b1, 1'b1, 4'd3, 8'hFF, 8'hFF);
        #1;
        total_cnt++;
        if (bus.req_ready !== 2'b01) $display("FAIL mw_ready: got %b expected 01", bus.req_ready);
        else pass_cnt++;
        tick();
        set_req(0, 1'b1, 1'b1, 4'd3, 8'h00, 8'h0F);
        tick();
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00, 8'h00);
        #1;
        total_cnt++;
        if (bus.rsp_valid !== 2'b00) $display("FAIL mw_no_rsp_on_write: got %b expected 00", bus.rsp_valid);
        else pass_cnt++;
        tick();
        set_req(0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        #1;
        total_cnt++;
        if (bus.rsp_valid !== 2'b01) $display("FAIL mw_rsp_valid: got %b expected 01", bus.rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.rsp_rdata !== 8'hF0) $display("FAIL mw_rdata: got %h expected f0", bus.rsp_rdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.rsp_valid !== 2'b00) $display("FAIL mw_rsp_drop: got %b expected 00", bus.rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.rsp_rdata !== 8'hF0) $display("FAIL mw_rdata_hold: got %h expected f0", bus.rsp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        logic [7:0] prev_d;
        do_reset();
        set_req(0, 1'b1, 1'b1, 4'd0, 8'h11, 8'hFF);
        tick();
        set_req(0, 1'b1, 1'b1, 4'd1, 8'h22, 8'hFF);
        tick();
        do_reset();
        set_req(0, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
        set_req(1, 1'b1, 1'b0, 4'd1, 8'h00, 8'h00);
        prev_g = 2'b00;
        prev_d = 8'h00;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            total_cnt++;
            if (bus.req_ready !== exp_g) $display("FAIL rr_grant%0d: got %b expected %b", k, bus.req_ready, exp_g);
            else pass_cnt++;
            if (k > 0) begin
                total_cnt++;
                if (bus.rsp_valid !== prev_g || bus.rsp_rdata !== prev_d)
                    $display("FAIL rr_rsp%0d: got %b/%h expected %b/%h", k, bus.rsp_valid, bus.rsp_rdata, prev_g, prev_d);
                else pass_cnt++;
            end
            prev_g = exp_g;
            prev_d = (k % 2 == 0) ? 8'h11 : 8'h22;
            tick();
        end
        idle_all();
        #1;
        total_cnt++;
        if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 8'h22)
            $display("FAIL rr_rsp_last: got %b/%h expected 10/22", bus.rsp_valid, bus.rsp_rdata);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 16'd6) $display("FAIL rr_stall: got %0d expected 6", stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_wr_rd_order;
        set_req(1, 1'b1, 1'b1, 4'd5, 8'hA5, 8'hFF);
        #1;
        total_cnt++;
        if (bus.req_ready !== 2'b10) $display("FAIL order_wr_grant: got %b expected 10", bus.req_ready);
        else pass_cnt++;
        tick();
        set_req(1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        set_req(0, 1'b1, 1'b0, 4'd5, 8'h00, 8'h00);
        tick();
        idle_all();
        #1;
        total_cnt++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 8'hA5)
            $display("FAIL order_rd: got %b/%h expected 01/a5", bus.rsp_valid, bus.rsp_rdata);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 16'd6) $display("FAIL order_stall_hold: got %0d expected 6", stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_zero_mask;
        set_req(0, 1'b1, 1'b1, 4'd7, 8'h3C, 8'hFF);
        tick();
        set_req(0, 1'b1, 1'b1, 4'd7, 8'hC3, 8'h00);
        #1;
        total_cnt++;
        if (bus.req_ready !== 2'b01) $display("FAIL zm_slot: got %b expected 01", bus.req_ready);
        else pass_cnt++;
        tick();
        set_req(0, 1'b1, 1'b0, 4'd7, 8'h00, 8'h00);
        tick();
        idle_all();
        #1;
        total_cnt++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 8'h3C)
            $display("FAIL zm_rd: got %b/%h expected 01/3c", bus.rsp_valid, bus.rsp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_saturation;
        logic [1:0] exp_s;
        do_reset();
        bus2.req_valid = 2'b11;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_s = (k >= 3) ? 2'b11 : 2'(k);
            total_cnt++;
            if (stall_cnt2 !== exp_s) $display("FAIL sat%0d: got %b expected %b", k, stall_cnt2, exp_s);
            else pass_cnt++;
        end
        idle_all();
    endtask

    task automatic test_reset_midstream;
        do_reset();
        set_req(0, 1'b1, 1'b1, 4'd2, 8'h5A, 8'hFF);
        tick();
        set_req(0, 1'b1, 1'b0, 4'd2, 8'h00, 8'h00);
        tick();
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b1, 4'd2, 8'h00, 8'hFF);
        set_req(1, 1'b1, 1'b0, 4'd2, 8'h00, 8'h00);
        #1;
        total_cnt++;
        if (bus.req_ready !== 2'b00) $display("FAIL mid_ready_in_reset: got %b expected 00", bus.req_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 8'h5A)
            $display("FAIL mid_rsp: got %b/%h expected 01/5a", bus.rsp_valid, bus.rsp_rdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.rsp_valid !== 2'b00) $display("FAIL mid_rsp_clear: got %b expected 00", bus.rsp_valid);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 4'd2, 8'h00, 8'h00);
        #1;
        total_cnt++;
        if (bus.req_ready !== 2'b01) $display("FAIL mid_ptr_reset: got %b expected 01", bus.req_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.rsp_valid !== 2'b00 || stall_cnt !== 16'd0)
            $display("FAIL mid_release: got %b/%0d expected 00/0", bus.rsp_valid, stall_cnt);
        else pass_cnt++;
        tick();
        idle_all();
        #1;
        total_cnt++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 8'h5A)
            $display("FAIL mid_no_write_in_reset: got %b/%h expected 01/5a", bus.rsp_valid, bus.rsp_rdata);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 16'd1) $display("FAIL mid_stall: got %0d expected 1", stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_pick;
        logic [3:0] v_tab [6] = '{4'b0000, 4'b1010, 4'b1010, 4'b0011, 4'b1111, 4'b0100};
        logic [1:0] p_tab [6] = '{2'd0,    2'd0,    2'd2,    2'd2,    2'd3,    2'd3};
        logic [3:0] g_tab [6] = '{4'b0000, 4'b0010, 4'b1000, 4'b0001, 4'b1000, 4'b0100};
        logic [1:0] i_tab [6] = '{2'd0,    2'd1,    2'd3,    2'd0,    2'd3,    2'd2};
        logic       f_tab [6] = '{1'b0,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1};
        for (int k = 0; k < 6; k++) begin
            pk_valid = v_tab[k];
            pk_ptr   = p_tab[k];
            #1;
            total_cnt++;
            if (pk_grant !== g_tab[k] || pk_vld !== f_tab[k] || (f_tab[k] && pk_idx !== i_tab[k]))
                $display("FAIL pick%0d: got %b/%0d/%b expected %b/%0d/%b",
                         k, pk_grant, pk_idx, pk_vld, g_tab[k], i_tab[k], f_tab[k]);
            else pass_cnt++;
        end
    endtask

    initial begin
        pk_valid = '0;
        pk_ptr   = '0;
        test_reset();
        test_masked_write();
        test_round_robin();
        test_wr_rd_order();
        test_zero_mask();
        test_saturation();
        test_reset_midstream();
        test_pick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
